// File: rtl/vram_pix_fetch_if.sv
// Purpose: bundles the line-control, VRAM display read port and pixel output of the fetch stage.
// Latency: none (wires only).
// Backpressure: none; pix_en is the only consumption signal, the VRAM port is fixed-latency.
interface vram_pix_fetch_if #(
  parameter int WORD  = 32,
  parameter int ADDRW = 14,
  parameter int BPP   = 4
);
  logic             frame_start;
  logic             line_start;
  logic             pix_en;
  logic [ADDRW-1:0] addr_base;
  logic [ADDRW-1:0] addr_disp;
  logic [WORD-1:0]  dout_disp;
  logic [BPP-1:0]   pix;
  logic             pix_valid;
  logic             underrun;

  // Timing/VRAM side: drives control and read data, observes address and pixels.
  modport master (
    output frame_start, line_start, pix_en, addr_base, dout_disp,
    input  addr_disp, pix, pix_valid, underrun
  );

  // Fetch stage side.
  modport slave (
    input  frame_start, line_start, pix_en, addr_base, dout_disp,
    output addr_disp, pix, pix_valid, underrun
  );
endinterface

// File: rtl/vram_pix_fetch.sv
// Purpose: prefetches one bitmap line from VRAM into a word FIFO and unpacks it into BPP-bit pixels.
// Latency: first pixel registered 4 cycles after line_start (read issue +1, 2-cycle VRAM, FIFO pop +1).
// Backpressure: reads issued only while FIFO occupancy plus in-flight reads < FIFO_DEPTH; pix_en drains.
// Option: VRAM_FETCH_LINE_DOUBLE_EN repeats every bitmap line twice (vertical 2x scale).
module vram_pix_fetch #(
  parameter int WORD       = 32,
  parameter int ADDRW      = 14,
  parameter int BPP        = 4,
  parameter int WIDTH      = 320,
  parameter int FIFO_DEPTH = 4
) (
  input logic               clk_pix,
  input logic               rst_pix_n,
  vram_pix_fetch_if.slave   bus
);

  localparam int LINE_WORDS = WIDTH * BPP / WORD;
  localparam int PPW        = WORD / BPP;
  localparam int CNTW       = $clog2(LINE_WORDS + 1);
  localparam int IDXW       = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int PTRW       = $clog2(FIFO_DEPTH);
  localparam int CW         = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} fetch_state_t;

  fetch_state_t     state, state_nxt;

  logic [ADDRW-1:0] line_addr;
  logic [ADDRW-1:0] fetch_base;
  logic [ADDRW-1:0] addr_disp_q;
  logic             first_line;
  logic [CNTW-1:0]  issued;
  logic             rd_vld1, rd_vld2;

  logic [WORD-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTRW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]    fifo_cnt;
  logic [CW:0]      occ;

  logic [WORD-1:0]  sh_word;
  logic [IDXW-1:0]  pix_idx;
  logic [CNTW-1:0]  words_used;
  logic             line_active;
  logic [BPP-1:0]   pix_q;
  logic             pix_valid_q;
  logic             underrun_q;

  logic             issue, push, pop, consume, last_pix, words_left;
  logic             first_eff, advance;
  logic [ADDRW-1:0] base_src, next_base;

`ifdef VRAM_FETCH_LINE_DOUBLE_EN
  logic             hold_line;
  logic             hold_eff;
`endif

  // Line base selection: a same-cycle frame_start restarts from addr_base.
  always_comb begin
    base_src  = bus.frame_start ? bus.addr_base : line_addr;
    first_eff = bus.frame_start | first_line;
`ifdef VRAM_FETCH_LINE_DOUBLE_EN
    hold_eff  = !bus.frame_start && hold_line;
    advance   = !first_eff && !hold_eff;
`else
    advance   = !first_eff;
`endif
    next_base = advance ? base_src + ADDRW'(LINE_WORDS) : base_src;
  end

  // Credit check counts in-flight reads so the FIFO can never overflow.
  always_comb begin
    occ        = (CW+1)'(fifo_cnt) + (CW+1)'(rd_vld1) + (CW+1)'(rd_vld2);
    issue      = (state == FETCH) && !bus.line_start &&
                 (occ < (CW+1)'(FIFO_DEPTH)) && (issued != CNTW'(LINE_WORDS));
    push       = rd_vld2 && !bus.line_start;
    consume    = bus.pix_en && pix_valid_q;
    last_pix   = (pix_idx == IDXW'(PPW - 1));
    words_left = (words_used != CNTW'(LINE_WORDS));
    pop        = !bus.line_start && (fifo_cnt != '0) && words_left &&
                 (!pix_valid_q || (consume && last_pix));
  end

  // Fetcher state register.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Fetcher next state: line_start always restarts the fetch.
  always_comb begin
    state_nxt = state;
    if (bus.line_start) begin
      state_nxt = FETCH;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        FETCH:   if (issue && issued == CNTW'(LINE_WORDS - 1)) state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Line address tracking across frame_start / line_start.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      line_addr  <= '0;
      fetch_base <= '0;
      first_line <= 1'b1;
`ifdef VRAM_FETCH_LINE_DOUBLE_EN
      hold_line  <= 1'b0;
`endif
    end else if (bus.line_start) begin
      line_addr  <= next_base;
      fetch_base <= next_base;
      first_line <= 1'b0;
`ifdef VRAM_FETCH_LINE_DOUBLE_EN
      hold_line  <= first_eff || !hold_eff;
`endif
    end else if (bus.frame_start) begin
      line_addr  <= bus.addr_base;
      first_line <= 1'b1;
`ifdef VRAM_FETCH_LINE_DOUBLE_EN
      hold_line  <= 1'b0;
`endif
    end
  end

  // Read issue and the 2-stage in-flight valid pipe; line_start drops stale reads.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      issued      <= '0;
      addr_disp_q <= '0;
      rd_vld1     <= 1'b0;
      rd_vld2     <= 1'b0;
    end else if (bus.line_start) begin
      issued      <= '0;
      rd_vld1     <= 1'b0;
      rd_vld2     <= 1'b0;
    end else begin
      rd_vld1 <= issue;
      rd_vld2 <= rd_vld1;
      if (issue) begin
        addr_disp_q <= fetch_base + ADDRW'(issued);
        issued      <= issued + CNTW'(1);
      end
    end
  end

  // Prefetch FIFO storage (no reset needed; pointers qualify contents).
  always_ff @(posedge clk_pix) begin
    if (push) fifo_mem[wr_ptr] <= bus.dout_disp;
  end

  // Prefetch FIFO pointers and occupancy.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (bus.line_start) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTRW'(1);
      if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

  // Unpacker: little-endian pixels, next word popped on the last pixel for gapless output.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      sh_word     <= '0;
      pix_idx     <= '0;
      words_used  <= '0;
      pix_q       <= '0;
      pix_valid_q <= 1'b0;
    end else if (bus.line_start) begin
      sh_word     <= '0;
      pix_idx     <= '0;
      words_used  <= '0;
      pix_q       <= '0;
      pix_valid_q <= 1'b0;
    end else if (pop) begin
      pix_q       <= fifo_mem[rd_ptr][BPP-1:0];
      sh_word     <= fifo_mem[rd_ptr] >> BPP;
      pix_idx     <= '0;
      words_used  <= words_used + CNTW'(1);
      pix_valid_q <= 1'b1;
    end else if (consume) begin
      if (last_pix) begin
        pix_q       <= '0;
        pix_valid_q <= 1'b0;
      end else begin
        pix_q   <= sh_word[BPP-1:0];
        sh_word <= sh_word >> BPP;
        pix_idx <= pix_idx + IDXW'(1);
      end
    end
  end

  // Line activity window and sticky underrun flag.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      line_active <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      if (bus.line_start)
        line_active <= 1'b1;
      else if (consume && last_pix && !words_left)
        line_active <= 1'b0;

      if (bus.frame_start)
        underrun_q <= 1'b0;
      else if (bus.pix_en && !pix_valid_q && line_active && !bus.line_start)
        underrun_q <= 1'b1;
    end
  end

  assign bus.addr_disp = addr_disp_q;
  assign bus.pix       = pix_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.underrun  = underrun_q;

endmodule

// File: tb/tb_vram_pix_fetch.sv
// Bench for vram_pix_fetch: WORD=32, BPP=4, WIDTH=16 (2 words/line, 8 pixels/word).
// Scoreboard queues hold expected read addresses and pixels; negedge monitors pop and compare.
module tb_vram_pix_fetch;
  logic clk;
  logic rst_n;

  vram_pix_fetch_if #(.WORD(32), .ADDRW(14), .BPP(4)) bus ();

  vram_pix_fetch #(
    .WORD(32), .ADDRW(14), .BPP(4), .WIDTH(16), .FIFO_DEPTH(4)
  ) dut (
    .clk_pix   (clk),
    .rst_pix_n (rst_n),
    .bus       (bus.slave)
  );

  logic [31:0] vmem [16384];
  logic [13:0] exp_addr [$];
  logic [3:0]  exp_pix  [$];
  logic [13:0] last_addr;
  int total;
  int bad;
  int lat;

`ifdef VRAM_FETCH_LINE_DOUBLE_EN
  localparam logic [13:0] LINE2_BASE = 14'h0100;
  localparam logic [13:0] FLUSH_A    = 14'h0100;
  localparam logic [13:0] FLUSH_B    = 14'h0102;
  localparam logic [13:0] DBL_B1     = 14'h0100;
  localparam logic [13:0] DBL_B2     = 14'h0102;
  localparam logic [13:0] DBL_B3     = 14'h0102;
`else
  localparam logic [13:0] LINE2_BASE = 14'h0102;
  localparam logic [13:0] FLUSH_A    = 14'h0102;
  localparam logic [13:0] FLUSH_B    = 14'h0104;
  localparam logic [13:0] DBL_B1     = 14'h0102;
  localparam logic [13:0] DBL_B2     = 14'h0104;
  localparam logic [13:0] DBL_B3     = 14'h0106;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM model: data for the address presented at edge t is on dout_disp for edge t+2.
  always @(posedge clk) bus.dout_disp <= vmem[bus.addr_disp];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected reads base, base+1 and the first npix pixels of those two words.
  task automatic expect_line(input logic [13:0] base, input int npix, input bit with_addr);
    logic [13:0] b1;
    logic [31:0] w;
    b1 = base + 14'd1;
    if (with_addr) begin
      exp_addr.push_back(base);
      exp_addr.push_back(b1);
    end
    for (int i = 0; i < npix; i++) begin
      w = (i < 8) ? vmem[base] : vmem[b1];
      exp_pix.push_back(w[4*(i%8) +: 4]);
    end
  endtask

  task automatic pulse_line(input bit fs, input bit ls, input logic [13:0] base);
    bus.addr_base   = base;
    bus.frame_start = fs;
    bus.line_start  = ls;
    tick();
    bus.frame_start = 1'b0;
    bus.line_start  = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.pix_valid && n < 12) begin
      tick();
      n++;
    end
    chk("pix_valid_wait", bus.pix_valid, 1'b1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_pix.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    chk("pix_drain", exp_pix.size(), 0);
  endtask

  // Monitor: address issues (seen as changes of addr_disp) and consumed pixels.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_addr = bus.addr_disp;
    end else begin
      if (bus.addr_disp !== last_addr) begin
        if (exp_addr.size() == 0) begin
          total++;
          bad++;
          $display("FAIL addr_unexpected: got %0h expected none", bus.addr_disp);
        end else begin
          chk("addr_disp", bus.addr_disp, exp_addr.pop_front());
        end
        last_addr = bus.addr_disp;
      end
      if (bus.pix_en && bus.pix_valid) begin
        if (exp_pix.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pix_unexpected: got %0h expected none", bus.pix);
        end else begin
          chk("pix", bus.pix, exp_pix.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 16384; i++) vmem[i] = 32'h0;
    vmem[14'h0100] = 32'h76543210;
    vmem[14'h0101] = 32'hFEDCBA98;
    vmem[14'h0102] = 32'h13579BDF;
    vmem[14'h0103] = 32'h02468ACE;
    vmem[14'h0104] = 32'h89ABCDEF;
    vmem[14'h0105] = 32'h31415926;
    vmem[14'h0106] = 32'h27182818;
    vmem[14'h0107] = 32'hDEADBEEF;
    vmem[14'h3FFF] = 32'hA5C3E1F0;
    vmem[14'h0000] = 32'h0F1E2D3C;

    rst_n           = 1'b0;
    bus.frame_start = 1'b0;
    bus.line_start  = 1'b0;
    bus.pix_en      = 1'b0;
    bus.addr_base   = '0;
    repeat (3) tick();
    chk("rst_addr_disp", bus.addr_disp, 14'h0);
    chk("rst_pix", bus.pix, 4'h0);
    chk("rst_pix_valid", bus.pix_valid, 1'b0);
    chk("rst_underrun", bus.underrun, 1'b0);
    rst_n = 1'b1;
    tick();

    // Base fetch and gapless unpack of 0x76543210 / 0xFEDCBA98.
    pulse_line(1'b1, 1'b0, 14'h0100);
    expect_line(14'h0100, 16, 1'b1);
    pulse_line(1'b0, 1'b1, 14'h0100);
    wait_valid(lat);
    chk("first_pix_latency_le5", (lat <= 5), 1'b1);
    bus.pix_en = 1'b1;
    repeat (16) tick();
    chk("eol_pix_valid", bus.pix_valid, 1'b0);
    chk("gapless_16_pixels", exp_pix.size(), 0);
    repeat (3) tick();
    chk("eol_pix_zero", bus.pix, 4'h0);
    chk("eol_no_underrun", bus.underrun, 1'b0);
    bus.pix_en = 1'b0;

    // Next line with pix_en held from the cycle after line_start: underrun.
    expect_line(LINE2_BASE, 16, 1'b1);
    pulse_line(1'b0, 1'b1, 14'h0000);
    bus.pix_en = 1'b1;
    repeat (2) tick();
    chk("underrun_set", bus.underrun, 1'b1);
    chk("underrun_pix_zero", bus.pix, 4'h0);
    wait_drain();
    tick();
    chk("underrun_sticky", bus.underrun, 1'b1);
    chk("line2_eol_valid", bus.pix_valid, 1'b0);
    bus.pix_en = 1'b0;

    // Mid-line flush, then a second flush while a read is in flight.
    pulse_line(1'b1, 1'b0, 14'h0100);
    chk("frame_clears_underrun", bus.underrun, 1'b0);
    expect_line(14'h0100, 3, 1'b1);
    pulse_line(1'b0, 1'b1, 14'h0000);
    wait_valid(lat);
    bus.pix_en = 1'b1;
    repeat (3) tick();
    bus.pix_en = 1'b0;
    chk("three_pix_consumed", exp_pix.size(), 0);
    exp_addr.push_back(FLUSH_A);
    expect_line(FLUSH_B, 16, 1'b1);
    pulse_line(1'b0, 1'b1, 14'h0000);
    tick();
    pulse_line(1'b0, 1'b1, 14'h0000);
    wait_valid(lat);
    bus.pix_en = 1'b1;
    wait_drain();
    bus.pix_en = 1'b0;

    // Address wrap; frame_start and line_start together fetch from addr_base.
    expect_line(14'h3FFF, 16, 1'b1);
    pulse_line(1'b1, 1'b1, 14'h3FFF);
    wait_valid(lat);
    chk("wrap_latency_le5", (lat <= 5), 1'b1);
    bus.pix_en = 1'b1;
    wait_drain();
    bus.pix_en = 1'b0;
    chk("wrap_no_underrun", bus.underrun, 1'b0);

    // Four lines in one frame: line base sequence.
    pulse_line(1'b1, 1'b0, 14'h0100);
    expect_line(14'h0100, 0, 1'b1);
    expect_line(DBL_B1, 0, 1'b1);
    expect_line(DBL_B2, 0, 1'b1);
    expect_line(DBL_B3, 0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      pulse_line(1'b0, 1'b1, 14'h0000);
      repeat (6) tick();
    end
    chk("line_seq_addrs_done", exp_addr.size(), 0);

    // Reset asserted mid-line with underrun set.
    expect_line(14'h0100, 16, 1'b1);
    pulse_line(1'b1, 1'b1, 14'h0100);
    bus.pix_en = 1'b1;
    wait_valid(lat);
    repeat (2) tick();
    chk("pre_reset_underrun", bus.underrun, 1'b1);
    #2;
    rst_n = 1'b0;
    exp_pix.delete();
    #1;
    chk("midrst_pix_valid", bus.pix_valid, 1'b0);
    chk("midrst_pix", bus.pix, 4'h0);
    chk("midrst_addr_disp", bus.addr_disp, 14'h0);
    chk("midrst_underrun", bus.underrun, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("postrst_underrun", bus.underrun, 1'b0);
    chk("postrst_pix_valid", bus.pix_valid, 1'b0);
    chk("postrst_addr_idle", bus.addr_disp, 14'h0);
    bus.pix_en = 1'b0;
    tick();
    chk("addr_queue_empty", exp_addr.size(), 0);
    chk("pix_queue_empty", exp_pix.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
